// File: rtl/esd_pkg.sv
// Shared constants and counter-width helpers for the E-STOP input conditioner.
package esd_pkg;

  localparam int   ESD_SYNC_STAGES = 2;
  localparam logic ESD_RST_PRESSED = 1'b1;

  // Counter wide enough to hold the value 'cycles' itself.
  function automatic int deb_cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

  function automatic int disc_cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/esd_debounce.sv
// One input channel: 2-flop synchronizer plus saturating debounce counter.
// IMMEDIATE_ASSERT=1 gives a fail-safe channel (press is taken at once, only release is debounced).
module esd_debounce
  import esd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 64,
  parameter bit IMMEDIATE_ASSERT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_n,
  output logic level
);

  localparam int             CW        = deb_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX   = CW'(DEBOUNCE_CYCLES);
  localparam logic           RST_LEVEL = IMMEDIATE_ASSERT ? ESD_RST_PRESSED : 1'b0;

  logic [ESD_SYNC_STAGES-1:0] sync_n;
  logic [ESD_SYNC_STAGES-1:0] primed;
  logic [CW-1:0]              cnt;
  logic                       pressed;

  assign pressed = ~sync_n[ESD_SYNC_STAGES-1];

  // The reset contents of the synchronizer never came from the pin, so the
  // counter stays idle until 'primed' shows the pipeline holds real samples.
  // NOTE: every register here is written with <= so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_n <= '1;
      primed <= '0;
    end else begin
      sync_n <= {sync_n[ESD_SYNC_STAGES-2:0], pin_n};
      primed <= {primed[ESD_SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= RST_LEVEL;
      cnt   <= '0;
    end else if (!primed[ESD_SYNC_STAGES-1]) begin
      cnt <= '0;
    end else if (IMMEDIATE_ASSERT && pressed) begin
      // Press beats a release count that would complete on this same edge.
      level <= 1'b1;
      cnt   <= '0;
    end else if (pressed == level) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      level <= pressed;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/esd_input_conditioner.sv
// E-STOP / ACK front end: three debounced channels, ACK release pulse, discrepancy monitor.
// Optional feature macro: ESD_DISCREPANCY_EN (builds disc_cnt and a live disc_fault).
module esd_input_conditioner
  import esd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 64,
  parameter int DISC_CYCLES     = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic estop_a_n_in,
  input  logic estop_b_n_in,
  input  logic ack_n_in,
  output logic estop_a,
  output logic estop_b,
  output logic estop_any,
  output logic ack_pulse,
  output logic disc_fault
);

  logic ack_level;
  logic ack_prev;

  esd_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IMMEDIATE_ASSERT(1'b1)) u_deb_a (
    .clk(clk), .rst_n(rst_n), .pin_n(estop_a_n_in), .level(estop_a));

  esd_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IMMEDIATE_ASSERT(1'b1)) u_deb_b (
    .clk(clk), .rst_n(rst_n), .pin_n(estop_b_n_in), .level(estop_b));

  esd_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IMMEDIATE_ASSERT(1'b0)) u_deb_ack (
    .clk(clk), .rst_n(rst_n), .pin_n(ack_n_in), .level(ack_level));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_prev <= 1'b0;
    else        ack_prev <= ack_level;
  end

  // High for the single cycle after the debounced level drops (release).
  assign ack_pulse = ack_prev & ~ack_level;

`ifdef ESD_DISCREPANCY_EN
  localparam int            DW        = disc_cnt_width(DISC_CYCLES);
  localparam logic [DW-1:0] DISC_MAX  = DW'(DISC_CYCLES);
  localparam logic [DW-1:0] DISC_LAST = DW'(DISC_CYCLES - 1);

  logic [DW-1:0] disc_cnt;
  logic          disagree;
  logic          disc_set;
  logic          disc_clr;

  assign disagree = estop_a ^ estop_b;
  assign disc_set = disagree && (disc_cnt == DISC_LAST);
  assign disc_clr = ack_pulse && !estop_a && !estop_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   disc_cnt <= '0;
    else if (!disagree)           disc_cnt <= '0;
    else if (disc_cnt != DISC_MAX) disc_cnt <= disc_cnt + DW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        disc_fault <= 1'b0;
    else if (disc_set) disc_fault <= 1'b1;
    else if (disc_clr) disc_fault <= 1'b0;
  end
`else
  // DISC_CYCLES has no effect here; folding it into the tie-off keeps it referenced.
  localparam logic DISC_TIE = (DISC_CYCLES < 0);
  assign disc_fault = DISC_TIE;
`endif

  assign estop_any = estop_a | estop_b | disc_fault;

endmodule

// File: tb/tb_esd_input_conditioner.sv
// Scoreboard bench for esd_input_conditioner: expected output vectors are queued per cycle
// when stimulus is applied and compared at the falling edge of that cycle.
module tb_esd_input_conditioner;

  localparam int DEB  = 64;
  localparam int DISC = 1000;
`ifdef ESD_DISCREPANCY_EN
  localparam logic DE = 1'b1;
`else
  localparam logic DE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic estop_a_n, estop_b_n, ack_n;
  logic estop_a, estop_b, estop_any, ack_pulse, disc_fault;

  int tests = 0;
  int fails = 0;
  int unsigned cyc;
  int ack_cnt;

  typedef struct {
    int unsigned cyc;
    string       tag;
    logic [4:0]  val;
  } sb_item_t;

  sb_item_t sb[$];

  esd_input_conditioner #(.DEBOUNCE_CYCLES(DEB), .DISC_CYCLES(DISC)) dut (
    .clk(clk), .rst_n(rst_n),
    .estop_a_n_in(estop_a_n), .estop_b_n_in(estop_b_n), .ack_n_in(ack_n),
    .estop_a(estop_a), .estop_b(estop_b), .estop_any(estop_any),
    .ack_pulse(ack_pulse), .disc_fault(disc_fault));

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected vector {estop_a, estop_b, estop_any, ack_pulse, disc_fault}.
  function automatic logic [4:0] vec(input logic a, input logic b, input logic p, input logic f);
    return {a, b, a | b | f, p, f};
  endfunction

  task automatic expect_at(input int unsigned c, input string tag, input logic [4:0] v);
    sb_item_t it;
    int i;
    it.cyc = c;
    it.tag = tag;
    it.val = v;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, it);
  endtask

  task automatic go_to(input int unsigned c);
    while (cyc != c) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ack_pulse) ack_cnt++;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        sb_item_t it;
        it = sb.pop_front();
        if (it.cyc == cyc)
          check(it.tag, {27'd0, estop_a, estop_b, estop_any, ack_pulse, disc_fault}, {27'd0, it.val});
        else
          check({it.tag, "_missed"}, cyc, it.cyc);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    estop_a_n = 1'b1;
    estop_b_n = 1'b1;
    ack_n = 1'b1;
    ack_cnt = 0;
    #23;
    check("reset_vals", {27'd0, estop_a, estop_b, estop_any, ack_pulse, disc_fault}, {27'd0, vec(1, 1, 0, 0)});

    // 1: post-reset release of both E-STOP channels
    expect_at(1,  "t1_edge1",  vec(1, 1, 0, 0));
    expect_at(66, "t1_edge66", vec(1, 1, 0, 0));
    expect_at(67, "t1_edge67", vec(0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    go_to(75);
    check("t1_no_pulse", ack_cnt, 0);

    // 2: single-cycle E-STOP A press
    go_to(80);
    estop_a_n = 1'b0;
    expect_at(82,  "t2_pre_assert", vec(0, 0, 0, 0));
    expect_at(83,  "t2_assert",     vec(1, 0, 0, 0));
    expect_at(147, "t2_hold",       vec(1, 0, 0, 0));
    expect_at(148, "t2_release",    vec(0, 0, 0, 0));
    go_to(81);
    estop_a_n = 1'b1;

    // 3: short ACK glitch, then a real press/release
    go_to(160);
    ack_cnt = 0;
    ack_n = 1'b0;
    go_to(190);
    ack_n = 1'b1;
    go_to(299);
    check("t3_glitch_no_pulse", ack_cnt, 0);
    go_to(300);
    ack_n = 1'b0;
    expect_at(466, "t3_pre_pulse",  vec(0, 0, 0, 0));
    expect_at(467, "t3_pulse",      vec(0, 0, 1, 0));
    expect_at(468, "t3_post_pulse", vec(0, 0, 0, 0));
    go_to(400);
    ack_n = 1'b1;
    go_to(500);
    check("t3_one_pulse", ack_cnt, 1);

    // 4: bouncing E-STOP B, final rise at 710
    expect_at(523, "t4_assert",   vec(0, 1, 0, 0));
    expect_at(600, "t4_bounce1",  vec(0, 1, 0, 0));
    expect_at(700, "t4_bounce2",  vec(0, 1, 0, 0));
    expect_at(776, "t4_hold",     vec(0, 1, 0, 0));
    expect_at(777, "t4_release",  vec(0, 0, 0, 0));
    for (int k = 0; k < 20; k++) begin
      go_to(520 + 10 * k);
      estop_b_n = k[0];
    end
    estop_b_n = 1'b1;

    // 5: discrepancy fault, ACK while held, then ACK after release
    go_to(800);
    estop_a_n = 1'b0;
    expect_at(803,  "t5_assert",     vec(1, 0, 0, 0));
    expect_at(1802, "t5_pre_fault",  vec(1, 0, 0, 0));
    expect_at(1803, "t5_fault",      vec(1, 0, 0, DE));
    expect_at(1947, "t5_ack_held",   vec(1, 0, 1, DE));
    expect_at(1948, "t5_fault_kept", vec(1, 0, 0, DE));
    expect_at(1966, "t5_a_hold",     vec(1, 0, 0, DE));
    expect_at(1967, "t5_a_release",  vec(0, 0, 0, DE));
    expect_at(2167, "t5_clr_pulse",  vec(0, 0, 1, DE));
    expect_at(2168, "t5_cleared",    vec(0, 0, 0, 0));
    go_to(1810);
    ack_n = 1'b0;
    go_to(1880);
    ack_n = 1'b1;
    go_to(1900);
    estop_a_n = 1'b1;
    go_to(2000);
    ack_n = 1'b0;
    go_to(2100);
    ack_n = 1'b1;

    // 6: reset in the middle of an A release debounce
    go_to(2200);
    estop_a_n = 1'b0;
    expect_at(2202, "t6_pre_assert", vec(0, 0, 0, 0));
    expect_at(2203, "t6_assert",     vec(1, 0, 0, 0));
    go_to(2210);
    estop_a_n = 1'b1;
    go_to(2240);
    check("t6_sb_empty", sb.size(), 0);
    rst_n = 1'b0;
    #1;
    check("t6_async_reset", {27'd0, estop_a, estop_b, estop_any, ack_pulse, disc_fault}, {27'd0, vec(1, 1, 0, 0)});
    expect_at(66, "t6_edge66", vec(1, 1, 0, 0));
    expect_at(67, "t6_edge67", vec(0, 0, 0, 0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    go_to(70);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
